// File: rtl/tart_vis_accum.sv
// tart_vis_accum: block accumulator for 1-bit correlation products.
// Sums CHANNELS product bits over a programmable block of strobed samples,
// then copies the block totals into a shadow bank and pulses switch.
// The shadow bank, status and blocksize are readable over a Wishbone-like bus.
//
// Ports
//   clk_i            clock (sample and bus domain)
//   rst_n            synchronous reset, active-low
//   enable           acquisition enable; dropping it discards the partial block
//   blocksize        samples per block minus 1, latched at the first strobe of a block
//   strobe, bits     sample valid, one product bit per channel
//   switch           one-cycle pulse after a new bank lands in the shadow
//   overflow         sticky, any channel saturated (SATURATE=1) or wrapped
//   cyc_i .. dat_i   bus request: cycle, strobe, write, burst-hold, address, data
//   ack_o, dat_o     bus acknowledge and read data (valid while ack_o)
module tart_vis_accum #(
    parameter int unsigned CHANNELS = 24,
    parameter int unsigned ACCUM    = 32,
    parameter int unsigned ADDR     = 6,
    parameter bit          SATURATE = 1'b1,
    parameter int unsigned DELAY    = 3
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [ACCUM-1:0]    blocksize,
    input  logic                strobe,
    input  logic [CHANNELS-1:0] bits,
    output logic                switch,
    output logic                overflow,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic                bst_i,
    input  logic [ADDR-1:0]     adr_i,
    input  logic [ACCUM-1:0]    dat_i,
    output logic                ack_o,
    output logic [ACCUM-1:0]    dat_o
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned STAT_W  = FRAME_W + 3;
    localparam logic [ADDR-1:0] ADR_CTRL = {ADDR{1'b1}};
    localparam logic [ADDR-1:0] ADR_STAT = ADR_CTRL - ADDR'(1);

    // DELAY is accepted for drop-in compatibility with the fixed correlator top;
    // registers here are modelled without delay.
    if (CHANNELS < 1 || CHANNELS > 60 || ACCUM < 2 ||
        (1 << ADDR) < CHANNELS + 2 || DELAY > 1000) begin : g_bad_param
        $error("tart_vis_accum: illegal parameter combination");
    end

    logic [ACCUM-1:0]   acc    [CHANNELS];
    logic [ACCUM-1:0]   shadow [CHANNELS];
    logic [ACCUM-1:0]   blk;
    logic [ACCUM-1:0]   blk_lim;
    logic [FRAME_W-1:0] frame;
    logic               ready;
    logic [CHANNELS-1:0] ovf;

    logic               strobe_en_c;
    logic [ACCUM-1:0]   lim_c;
    logic               wrap_c;
    logic               bus_req_c;
    logic               ctrl_wr_c;
    logic [ACCUM:0]     sum_c;
    logic [ACCUM-1:0]   nxt_c  [CHANNELS];
    logic [CHANNELS-1:0] hit_c;
    logic [CHANNELS-1:0] ovf_nxt_c;
    logic               ready_nxt_c;
    logic [STAT_W-1:0]  stat_c;
    logic [ACCUM-1:0]   rd_c;
    logic               unused_dat_c;

    // Only the two clear bits of the control word carry meaning.
    assign unused_dat_c = ^dat_i;

    // Block control, per-channel add with saturate/wrap, flag updates.
    always_comb begin
        strobe_en_c = enable && strobe;
        // blocksize is taken live on the first strobe of a block, held afterwards
        lim_c       = (blk == '0) ? blocksize : blk_lim;
        wrap_c      = strobe_en_c && (blk == lim_c);
        bus_req_c   = cyc_i && stb_i && (bst_i || !ack_o);
        ctrl_wr_c   = bus_req_c && we_i && (adr_i == ADR_CTRL);
        sum_c       = '0;
        hit_c       = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum_c    = {1'b0, acc[c]} + (ACCUM+1)'(bits[c]);
            hit_c[c] = strobe_en_c && sum_c[ACCUM];
            nxt_c[c] = (sum_c[ACCUM] && SATURATE) ? {ACCUM{1'b1}} : sum_c[ACCUM-1:0];
        end
        // A fresh overflow beats a clear in the same cycle; a wrap beats a ready clear.
        ovf_nxt_c   = hit_c | ((ctrl_wr_c && dat_i[1]) ? '0 : ovf);
        ready_nxt_c = wrap_c ? 1'b1 : ((ctrl_wr_c && dat_i[0]) ? 1'b0 : ready);
    end

    // Read mux; shadow is read before any swap in this cycle.
    always_comb begin
        stat_c = {ready, overflow, SATURATE, frame};
        rd_c   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (adr_i == ADDR'(c)) rd_c = shadow[c];
        end
        if (adr_i == ADR_STAT) rd_c = ACCUM'(stat_c);
        if (adr_i == ADR_CTRL) rd_c = blocksize;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c]    <= '0;
                shadow[c] <= '0;
            end
            blk      <= '0;
            blk_lim  <= '0;
            frame    <= '0;
            ready    <= 1'b0;
            ovf      <= '0;
            switch   <= 1'b0;
            overflow <= 1'b0;
            ack_o    <= 1'b0;
            dat_o    <= '0;
        end else begin
            if (!enable) begin
                blk <= '0;
                for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
            end else if (strobe) begin
                if (wrap_c) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        shadow[c] <= nxt_c[c];
                        acc[c]    <= '0;
                    end
                    blk   <= '0;
                    frame <= frame + FRAME_W'(1);
                end else begin
                    for (int c = 0; c < CHANNELS; c++) acc[c] <= nxt_c[c];
                    blk <= blk + ACCUM'(1);
                    if (blk == '0) blk_lim <= blocksize;
                end
            end
            switch   <= wrap_c;
            ready    <= ready_nxt_c;
            ovf      <= ovf_nxt_c;
            overflow <= |ovf_nxt_c;
            ack_o    <= bus_req_c;
            dat_o    <= (bus_req_c && !we_i) ? rd_c : '0;
        end
    end

endmodule

// File: tb/tb_tart_vis_accum.sv
// Directed bench: three instances share all inputs. Instance a is 4 channels x
// 32 bits; b and c are 4 channels x 4 bits, saturating and wrapping.
module tb_tart_vis_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] blocksize;
    logic        strobe;
    logic [3:0]  bits;
    logic        cyc, stb, we, bst;
    logic [2:0]  adr;
    logic [31:0] dat_w;

    logic        switch_a, ovf_a, ack_a;
    logic [31:0] dat_a;
    logic        switch_b, ovf_b, ack_b;
    logic [3:0]  dat_b;
    logic        switch_c, ovf_c, ack_c;
    logic [3:0]  dat_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tart_vis_accum #(.CHANNELS(4), .ACCUM(32), .ADDR(3), .SATURATE(1'b1), .DELAY(3)) dut_a (
        .clk_i(clk), .rst_n(rst_n), .enable(enable), .blocksize(blocksize),
        .strobe(strobe), .bits(bits), .switch(switch_a), .overflow(ovf_a),
        .cyc_i(cyc), .stb_i(stb), .we_i(we), .bst_i(bst), .adr_i(adr),
        .dat_i(dat_w), .ack_o(ack_a), .dat_o(dat_a));

    tart_vis_accum #(.CHANNELS(4), .ACCUM(4), .ADDR(3), .SATURATE(1'b1), .DELAY(3)) dut_b (
        .clk_i(clk), .rst_n(rst_n), .enable(enable), .blocksize(blocksize[3:0]),
        .strobe(strobe), .bits(bits), .switch(switch_b), .overflow(ovf_b),
        .cyc_i(cyc), .stb_i(stb), .we_i(we), .bst_i(bst), .adr_i(adr),
        .dat_i(dat_w[3:0]), .ack_o(ack_b), .dat_o(dat_b));

    tart_vis_accum #(.CHANNELS(4), .ACCUM(4), .ADDR(3), .SATURATE(1'b0), .DELAY(3)) dut_c (
        .clk_i(clk), .rst_n(rst_n), .enable(enable), .blocksize(blocksize[3:0]),
        .strobe(strobe), .bits(bits), .switch(switch_c), .overflow(ovf_c),
        .cyc_i(cyc), .stb_i(stb), .we_i(we), .bst_i(bst), .adr_i(adr),
        .dat_i(dat_w[3:0]), .ack_o(ack_c), .dat_o(dat_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; bst = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic ak, output logic [31:0] d,
                            output logic [3:0] db, output logic [3:0] dc);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; bst = 1'b0; adr = a;
        tick();
        ak = ack_a; d = dat_a; db = dat_b; dc = dat_c;
        bus_idle();
        tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; bst = 1'b0; adr = a; dat_w = v;
        tick();
        bus_idle();
        tick();
    endtask

    task automatic strobes(input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++) begin
            strobe = 1'b1; bits = b;
            tick();
        end
        strobe = 1'b0; bits = '0;
    endtask

    task automatic test_reset();
        logic ak; logic [31:0] d; logic [3:0] db, dc;
        rst_n = 1'b0; enable = 1'b0; blocksize = '0; strobe = 1'b0; bits = '0;
        bus_idle(); adr = '0; dat_w = '0;
        tick(); tick();
        checks++; if (switch_a !== 1'b0) begin failures++; $display("FAIL reset_switch got=%b exp=0", switch_a); end
        checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", ovf_a); end
        checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack_a); end
        checks++; if (dat_a !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0", dat_a); end
        rst_n = 1'b1;
        tick();
        bus_read(3'd0, ak, d, db, dc);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_shadow0 got=%h exp=0", d); end
        bus_read(3'd6, ak, d, db, dc);
        checks++; if (d !== 32'h0001_0000) begin failures++; $display("FAIL reset_status got=%h exp=00010000", d); end
    endtask

    task automatic test_block();
        logic ak; logic [31:0] d; logic [3:0] db, dc;
        logic [3:0] pat;
        pat = 4'b1011;
        blocksize = 32'd7; enable = 1'b1;
        strobes(7, pat);
        checks++; if (switch_a !== 1'b0) begin failures++; $display("FAIL block_early_switch got=%b exp=0", switch_a); end
        strobe = 1'b1; bits = pat;
        tick();
        strobe = 1'b0; bits = '0;
        checks++; if (switch_a !== 1'b1) begin failures++; $display("FAIL block_switch got=%b exp=1", switch_a); end
        tick();
        checks++; if (switch_a !== 1'b0) begin failures++; $display("FAIL block_switch_width got=%b exp=0", switch_a); end
        for (int i = 0; i < 4; i++) begin
            bus_read(3'(i), ak, d, db, dc);
            checks++;
            if (ak !== 1'b1 || d !== (pat[i] ? 32'd8 : 32'd0)) begin
                failures++; $display("FAIL block_shadow%0d got ack=%b dat=%0d exp ack=1 dat=%0d", i, ak, d, pat[i] ? 8 : 0);
            end
        end
        bus_read(3'd6, ak, d, db, dc);
        checks++; if (d !== 32'h0005_0001) begin failures++; $display("FAIL block_status got=%h exp=00050001", d); end
    endtask

    task automatic test_burst();
        logic [31:0] exp_sh [4];
        logic ak; logic [31:0] d; logic [3:0] db, dc;
        exp_sh[0] = 32'd8; exp_sh[1] = 32'd8; exp_sh[2] = 32'd0; exp_sh[3] = 32'd8;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; bst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            adr = 3'(i);
            tick();
            checks++;
            if (ack_a !== 1'b1 || dat_a !== exp_sh[i]) begin
                failures++; $display("FAIL burst_beat%0d got ack=%b dat=%0d exp ack=1 dat=%0d", i, ack_a, dat_a, exp_sh[i]);
            end
        end
        bus_idle();
        tick();
        checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL burst_end_ack got=%b exp=0", ack_a); end
        cyc = 1'b1; stb = 1'b1; bst = 1'b0; adr = 3'd5;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ack_a !== ((i % 2) == 0)) begin
                failures++; $display("FAIL single_ack%0d got=%b exp=%0d", i, ack_a, (i % 2) == 0);
            end
            if (ack_a === 1'b1) begin
                checks++; if (dat_a !== 32'h0) begin failures++; $display("FAIL unmapped5 got=%h exp=0", dat_a); end
            end
        end
        bus_idle();
        tick();
        bus_read(3'd4, ak, d, db, dc);
        checks++; if (ak !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL unmapped4 got ack=%b dat=%h exp ack=1 dat=0", ak, d); end
    endtask

    task automatic test_stream();
        logic ak; logic [31:0] d; logic [3:0] db, dc;
        int pulses, first_at, second_at;
        pulses = 0; first_at = -1; second_at = -1;
        blocksize = 32'd3;
        for (int i = 0; i < 24; i++) begin
            strobe = ((i % 3) == 0);
            bits   = (((i / 3) % 2) == 0) ? 4'hF : 4'h0;
            tick();
            if (switch_a === 1'b1) begin
                if (pulses == 0) first_at = i; else if (pulses == 1) second_at = i;
                pulses++;
            end
        end
        strobe = 1'b0; bits = '0;
        checks++; if (pulses != 2) begin failures++; $display("FAIL stream_pulses got=%0d exp=2", pulses); end
        checks++; if (first_at != 9 || second_at - first_at != 12) begin
            failures++; $display("FAIL stream_period got first=%0d period=%0d exp first=9 period=12", first_at, second_at - first_at);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(3'(i), ak, d, db, dc);
            checks++; if (d !== 32'd2) begin failures++; $display("FAIL stream_shadow%0d got=%0d exp=2", i, d); end
        end
        bus_read(3'd6, ak, d, db, dc);
        checks++; if (d !== 32'h0005_0003) begin failures++; $display("FAIL stream_status got=%h exp=00050003", d); end
    endtask

    task automatic test_enable_drop();
        logic ak; logic [31:0] d; logic [3:0] db, dc;
        blocksize = 32'd7;
        strobes(5, 4'hF);
        checks++; if (switch_a !== 1'b0) begin failures++; $display("FAIL drop_switch got=%b exp=0", switch_a); end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        bus_read(3'd0, ak, d, db, dc);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL drop_shadow_kept got=%0d exp=2", d); end
        strobes(8, 4'b0001);
        checks++; if (switch_a !== 1'b1) begin failures++; $display("FAIL drop_restart_switch got=%b exp=1", switch_a); end
        bus_read(3'd0, ak, d, db, dc);
        checks++; if (d !== 32'd8) begin failures++; $display("FAIL drop_new_ch0 got=%0d exp=8", d); end
        bus_read(3'd1, ak, d, db, dc);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL drop_new_ch1 got=%0d exp=0", d); end
        cyc = 1'b1; stb = 1'b1; we = 1'b0; bst = 1'b1; adr = 3'd0;
        tick();
        checks++; if (ack_a !== 1'b1) begin failures++; $display("FAIL midburst_ack got=%b exp=1", ack_a); end
        rst_n = 1'b0;
        tick();
        checks++; if (ack_a !== 1'b0 || dat_a !== 32'h0 || switch_a !== 1'b0 || ovf_a !== 1'b0) begin
            failures++; $display("FAIL midburst_reset got ack=%b dat=%h sw=%b ovf=%b exp all 0", ack_a, dat_a, switch_a, ovf_a);
        end
        rst_n = 1'b1; bus_idle();
        tick();
        bus_read(3'd6, ak, d, db, dc);
        checks++; if (d !== 32'h0001_0000) begin failures++; $display("FAIL postreset_status got=%h exp=00010000", d); end
    endtask

    task automatic test_collision();
        logic ak; logic [31:0] d; logic [3:0] db, dc;
        enable = 1'b1; blocksize = 32'd1;
        strobes(2, 4'b0001);
        strobe = 1'b1; bits = 4'b0000;
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; bst = 1'b0; adr = 3'd0;
        tick();
        checks++; if (ack_a !== 1'b1 || dat_a !== 32'd2) begin
            failures++; $display("FAIL collide_read got ack=%b dat=%0d exp ack=1 dat=2", ack_a, dat_a);
        end
        strobe = 1'b0; bus_idle();
        tick();
        bus_read(3'd0, ak, d, db, dc);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL collide_newbank got=%0d exp=0", d); end
        strobes(1, 4'b0001);
        strobe = 1'b1; bits = 4'b0001;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd7; dat_w = 32'h1;
        tick();
        strobe = 1'b0; bits = '0; bus_idle();
        tick();
        bus_read(3'd6, ak, d, db, dc);
        checks++; if (d !== 32'h0005_0003) begin failures++; $display("FAIL collide_ready got=%h exp=00050003", d); end
        bus_write(3'd7, 32'h1);
        bus_read(3'd6, ak, d, db, dc);
        checks++; if (d !== 32'h0001_0003) begin failures++; $display("FAIL ready_clear got=%h exp=00010003", d); end
    endtask

    task automatic test_saturate();
        logic ak; logic [31:0] d; logic [3:0] db, dc;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; enable = 1'b1; blocksize = 32'd15;
        strobes(16, 4'hF);
        checks++; if (ovf_b !== 1'b1 || ovf_c !== 1'b1 || ovf_a !== 1'b0) begin
            failures++; $display("FAIL sat_overflow got a=%b b=%b c=%b exp a=0 b=1 c=1", ovf_a, ovf_b, ovf_c);
        end
        bus_read(3'd0, ak, d, db, dc);
        checks++; if (d !== 32'd16 || db !== 4'd15 || dc !== 4'd0) begin
            failures++; $display("FAIL sat_shadow got a=%0d b=%0d c=%0d exp a=16 b=15 c=0", d, db, dc);
        end
        blocksize = 32'd3;
        strobes(4, 4'hF);
        bus_read(3'd1, ak, d, db, dc);
        checks++; if (d !== 32'd4 || db !== 4'd4 || dc !== 4'd4) begin
            failures++; $display("FAIL sat_restart got a=%0d b=%0d c=%0d exp 4", d, db, dc);
        end
        checks++; if (ovf_b !== 1'b1 || ovf_c !== 1'b1) begin
            failures++; $display("FAIL sat_sticky got b=%b c=%b exp 1", ovf_b, ovf_c);
        end
        bus_write(3'd7, 32'h2);
        checks++; if (ovf_b !== 1'b0 || ovf_c !== 1'b0) begin
            failures++; $display("FAIL ovf_clear got b=%b c=%b exp 0", ovf_b, ovf_c);
        end
    endtask

    initial begin
        test_reset();
        test_block();
        test_burst();
        test_stream();
        test_enable_drop();
        test_collision();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

endmodule
